branch_redirect_ctrl: RTL
=========================

Name: branch_redirect_ctrl

Overview:
- Sequences control-flow resolution in the EX stage of the 5-stage RV32I pipeline.
- Consumes the taken/not-taken decision from the branch comparator plus jump decode, and computes the target.
- Issues a valid/ready redirect to the fetch unit and holds EX while the redirect is pending.
- Drives a timed flush of the IF/ID and ID/EX registers, raises misaligned-target exceptions, and keeps saturating perf counters.

Parameters:
XLEN, 32, datapath/address width
FLUSH_CYCLES, 2, cycles flush stays high after fetch accepts the redirect (1..7)
CNT_W, 32, perf counter width

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous active-high reset
ex_valid  in  1  EX holds a real instruction
ex_is_branch  in  1  EX instruction is B-type
ex_is_jal  in  1  EX instruction is JAL
ex_is_jalr  in  1  EX instruction is JALR
branch_taken  in  1  comparator result; meaningful only when ex_is_branch
ex_pc  in  XLEN  PC of EX instruction
ex_imm  in  XLEN  sign-extended immediate
ex_rs1  in  XLEN  forwarded rs1 value
redir_valid  out  1  redirect request to fetch
redir_ready  in  1  fetch accepts redirect
redir_pc  out  XLEN  redirect target
flush  out  1  invalidate IF/ID and ID/EX
ex_stall  out  1  freeze EX and earlier stages
misalign_exc  out  1  one-cycle pulse: target not 4-byte aligned
misalign_addr  out  XLEN  offending target, held until next exception
perf_resolved  out  CNT_W  count of resolved branches and jumps
perf_redirects  out  CNT_W  count of accepted redirects

Behaviour:
- Reset (sync, rst=1 at clock edge): state=IDLE. All outputs 0, including counters and misalign_addr. Reset overrides every in-flight activity; a pending redirect is dropped.
- Resolve event: IDLE and ex_valid and (ex_is_branch or ex_is_jal or ex_is_jalr). Events are ignored outside IDLE, because EX holds a stalled or flushed slot.
- take = ex_is_jal | ex_is_jalr | (ex_is_branch & branch_taken). If more than one is_* flag is set, priority is jalr > jal > branch.
- Target arithmetic is modulo 2^XLEN:
  - branch/JAL: ex_pc + ex_imm.
  - JALR: (ex_rs1 + ex_imm) with bit0 forced to 0.
- perf_resolved increments on every resolve event. perf_redirects increments on each redir_valid & redir_ready cycle. Both saturate at all-ones with no wrap.
- IDLE, on resolve event:
  - take=0: stay IDLE, no other action.
  - take=1 and target[1]=1: pulse misalign_exc next cycle, load misalign_addr, no redirect, no flush, stay IDLE.
  - take=1 and aligned: register redir_pc, go to REDIRECT.
- REDIRECT:
  - redir_valid=1, flush=1, ex_stall=1.
  - redir_pc is stable while valid and not ready.
  - On redir_valid & redir_ready: load flush counter = FLUSH_CYCLES, go to FLUSH.
  - redir_ready is a don't-care outside REDIRECT.
- FLUSH:
  - flush=1, ex_stall=0, redir_valid=0.
  - Counter decrements each cycle; when it reaches 1, the next state is IDLE.
  - flush is therefore high for exactly FLUSH_CYCLES cycles after acceptance.
- Latency:
  - Resolve cycle N gives redir_valid and flush high from N+1.
  - Acceptance at cycle M gives IDLE at M+FLUSH_CYCLES+1.
  - The earliest next resolve is that cycle.
- The branch comparator must output 0 when its branch-enable is low; this block still gates branch_taken with ex_is_branch.

Decomposition:
- Shared package holds:
  - FSM state encoding: IDLE=2'd0, REDIRECT=2'd1, FLUSH=2'd2.
  - Alignment mask constant.
  - Default FLUSH_CYCLES.
- One natural sub-module, sat_counter (parameter CNT_W; inputs inc and clear), instantiated twice for the perf counters.
- Target adder and FSM stay in the top module.

Test Plan:
- BEQ taken: ex_pc=0x100, ex_imm=0x20, branch_taken=1, redir_ready=1 one cycle later → redir_pc=0x120, one accept cycle, flush high 1+2 cycles, perf_redirects=1, perf_resolved=1.
- JALR with backpressure: ex_rs1=0x2001, ex_imm=0x4, redir_ready=0 for 3 cycles → redir_pc=0x2004 held stable, ex_stall=1 for 4 cycles, then FLUSH for 2 cycles.
- Not-taken BNE: ex_is_branch=1, branch_taken=0 → no redir_valid, no flush, perf_resolved=1, perf_redirects=0.
- Misaligned JAL: ex_pc=0x100, ex_imm=0x6 → misalign_exc pulses one cycle, misalign_addr=0x106, redir_valid never asserts, state stays IDLE.
- Reset mid-REDIRECT: assert rst while redir_valid=1 → next cycle all outputs 0, counters 0; a subsequent branch resolves normally.
- Counter saturation with CNT_W=4: 20 taken branches → perf_resolved and perf_redirects stop at 0xF.

Source files
------------

// File: rtl/branch_redirect_ctrl_pkg.sv
// ============================================================================
// Module      : branch_redirect_ctrl_pkg
// Description : Shared constants for the EX-stage branch redirect controller.
//               The package holds the FSM state encoding, the target
//               alignment mask and the default flush length.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package branch_redirect_ctrl_pkg;

    // Controller states
    localparam logic [1:0] c_ST_IDLE     = 2'd0;
    localparam logic [1:0] c_ST_REDIRECT = 2'd1;
    localparam logic [1:0] c_ST_FLUSH    = 2'd2;

    // RV32I without the C extension needs 4-byte aligned targets. Bit 0 is
    // always 0, because JALR clears it and branch/JAL offsets are even.
    // Only bit 1 can therefore flag a misaligned target.
    localparam logic [1:0] c_ALIGN_MASK = 2'b10;

    // Default number of cycles that flush stays high after fetch accepts
    localparam int unsigned c_FLUSH_CYCLES_DEFAULT = 2;

endpackage : branch_redirect_ctrl_pkg

`default_nettype wire

// File: rtl/branch_redirect_ctrl_sat_counter.sv
// ============================================================================
// Module      : sat_counter
// Description : Up-counter that saturates at all-ones and never wraps.
//               A synchronous clear takes priority over an increment.
// Ports       : clk   - clock
//               clear - synchronous clear to zero
//               inc   - increment request
//               count - current count value
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sat_counter #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (clear) begin
            r_count <= '0;
        end else if (inc && (r_count != {CNT_W{1'b1}})) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign count = r_count;

endmodule : sat_counter

`default_nettype wire

// File: rtl/branch_redirect_ctrl.sv
// ============================================================================
// Module      : branch_redirect_ctrl
// Description : Resolves control flow in the EX stage of the RV32I pipeline.
//               The module computes the branch or jump target and sends a
//               valid/ready redirect to fetch. It stalls EX while the
//               redirect is pending, then holds a timed flush of IF/ID and
//               ID/EX. A misaligned target raises a one-cycle exception.
//               Two saturating perf counters track resolved branches and
//               jumps, and accepted redirects.
// Ports       : clk, rst                 - clock, synchronous active-high reset
//               ex_valid, ex_is_*        - EX slot and decode information
//               branch_taken             - comparator result
//               ex_pc, ex_imm, ex_rs1    - target operands
//               redir_valid/ready/pc     - redirect handshake to fetch
//               flush, ex_stall          - pipeline control
//               misalign_exc/addr        - misaligned-target exception
//               perf_resolved/redirects  - saturating event counters
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module branch_redirect_ctrl
    import branch_redirect_ctrl_pkg::*;
#(
    parameter int unsigned XLEN         = 32,
    parameter int unsigned FLUSH_CYCLES = c_FLUSH_CYCLES_DEFAULT,
    parameter int unsigned CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ex_valid,
    input  logic             ex_is_branch,
    input  logic             ex_is_jal,
    input  logic             ex_is_jalr,
    input  logic             branch_taken,
    input  logic [XLEN-1:0]  ex_pc,
    input  logic [XLEN-1:0]  ex_imm,
    input  logic [XLEN-1:0]  ex_rs1,
    output logic             redir_valid,
    input  logic             redir_ready,
    output logic [XLEN-1:0]  redir_pc,
    output logic             flush,
    output logic             ex_stall,
    output logic             misalign_exc,
    output logic [XLEN-1:0]  misalign_addr,
    output logic [CNT_W-1:0] perf_resolved,
    output logic [CNT_W-1:0] perf_redirects
);

    localparam logic [2:0] c_FLUSH_LOAD = 3'(FLUSH_CYCLES);

    logic [1:0]      r_state;
    logic [1:0]      w_state_nxt;
    logic [2:0]      r_flush_cnt;
    logic [XLEN-1:0] r_redir_pc;
    logic            r_misalign_exc;
    logic [XLEN-1:0] r_misalign_addr;

    logic            w_event;
    logic            w_take;
    logic [XLEN-1:0] w_jalr_sum;
    logic [XLEN-1:0] w_target;
    logic            w_misaligned;
    logic            w_accept;

    // ------------------------------------------------------------------
    // Resolve decision and target
    // ------------------------------------------------------------------
    // An event is accepted only in IDLE. In any other state, EX holds a
    // stalled or already-flushed slot.
    assign w_event    = (r_state == c_ST_IDLE) && ex_valid
                        && (ex_is_branch || ex_is_jal || ex_is_jalr);
    assign w_take     = ex_is_jal || ex_is_jalr || (ex_is_branch && branch_taken);
    assign w_jalr_sum = ex_rs1 + ex_imm;
    // JALR has top priority. A branch that is also flagged as JAL uses the
    // same pc+imm target, so no third arm is needed.
    assign w_target   = ex_is_jalr ? {w_jalr_sum[XLEN-1:1], 1'b0} : (ex_pc + ex_imm);
    assign w_misaligned = |(w_target[1:0] & c_ALIGN_MASK);
    assign w_accept   = (r_state == c_ST_REDIRECT) && redir_ready;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (w_event && w_take && !w_misaligned) begin
                    w_state_nxt = c_ST_REDIRECT;
                end
            end
            c_ST_REDIRECT: begin
                if (redir_ready) begin
                    w_state_nxt = c_ST_FLUSH;
                end
            end
            c_ST_FLUSH: begin
                if (r_flush_cnt <= 3'd1) begin
                    w_state_nxt = c_ST_IDLE;
                end
            end
            default: w_state_nxt = c_ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        redir_valid = 1'b0;
        flush       = 1'b0;
        ex_stall    = 1'b0;
        case (r_state)
            c_ST_REDIRECT: begin
                redir_valid = 1'b1;
                flush       = 1'b1;
                ex_stall    = 1'b1;
            end
            c_ST_FLUSH: begin
                flush       = 1'b1;
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_flush_cnt     <= 3'd0;
            r_redir_pc      <= '0;
            r_misalign_exc  <= 1'b0;
            r_misalign_addr <= '0;
        end else begin
            r_misalign_exc <= 1'b0;
            if (w_event && w_take) begin
                if (w_misaligned) begin
                    r_misalign_exc  <= 1'b1;
                    r_misalign_addr <= w_target;
                end else begin
                    // Loaded only from IDLE, so the target stays stable
                    // while REDIRECT waits for ready.
                    r_redir_pc <= w_target;
                end
            end
            if (w_accept) begin
                r_flush_cnt <= c_FLUSH_LOAD;
            end else if (r_state == c_ST_FLUSH) begin
                r_flush_cnt <= r_flush_cnt - 3'd1;
            end
        end
    end

    assign redir_pc      = r_redir_pc;
    assign misalign_exc  = r_misalign_exc;
    assign misalign_addr = r_misalign_addr;

    // ------------------------------------------------------------------
    // Performance counters
    // ------------------------------------------------------------------
    sat_counter #(.CNT_W(CNT_W)) u_cnt_resolved (
        .clk   (clk),
        .clear (rst),
        .inc   (w_event),
        .count (perf_resolved)
    );

    sat_counter #(.CNT_W(CNT_W)) u_cnt_redirects (
        .clk   (clk),
        .clear (rst),
        .inc   (w_accept),
        .count (perf_redirects)
    );

endmodule : branch_redirect_ctrl

`default_nettype wire
